// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory stage: stack operation codes,
// the memory-stage state encoding and the default stack pointer reset value.
package cpu_pkg;

  localparam logic [1:0] SP_NONE = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;

  // Stack grows downward in whole words.
  localparam int unsigned SP_STEP = 4;

  localparam logic [31:0] SP_RESET_DEFAULT = 32'h0000_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer register with push/pop update and the address mux that
// selects sp-4 for a push (pre-decrement) or sp for any other stack access.
module stack_ptr
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd,
  input  logic [1:0]        upd_op,
  input  logic [1:0]        cur_op,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] stack_addr
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(SP_STEP);

  // Commit the latched stack operation when its memory access completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= SP_RESET;
    end else if (upd) begin
      if (upd_op == SP_PUSH) begin
        sp <= sp - STEP;
      end else if (upd_op == SP_POP) begin
        sp <= sp + STEP;
      end
    end
  end

  assign stack_addr = (cur_op == SP_PUSH) ? (sp - STEP) : sp;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: performs the data-memory access described by the
// EX/MEM register over a req/ack port, owns the stack pointer, stalls the
// upstream pipeline while an access is outstanding and registers the MEM/WB
// writeback bundle.
//
// Optional feature: define MEM_TIMEOUT_EN to bound the wait for mem_ack to
// TIMEOUT BUSY cycles; a timeout sets the sticky mem_err flag, returns zero
// read data and leaves the stack pointer untouched. The TIMEOUT parameter
// exists only in that build; otherwise BUSY waits indefinitely and mem_err
// is tied low.
module mem_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEFAULT)
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        reg_dst,
  input  logic              reg_wr,
  input  logic              wb_sel,
  input  logic              mem_addr_sel,
  input  logic              mem_wr,
  input  logic [1:0]        sp_select,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        wb_dst,
  output logic              wb_wr,
  output logic [DATA_W-1:0] sp,
  output logic              mem_err
);

  mem_state_t        state;
  logic [1:0]        sp_op_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] stack_addr;
  logic [DATA_W-1:0] acc_addr;
  logic              access;
  logic              sp_upd;
  logic              tmo_hit;

  assign access   = wb_sel | mem_wr;
  assign acc_addr = mem_addr_sel ? stack_addr : alu_out;
  assign stall    = ((state == IDLE) && access) || (state == BUSY);
  // Only a real acknowledge moves the stack pointer; a timeout does not.
  assign sp_upd   = (state == BUSY) && mem_ack;

  stack_ptr #(
    .DATA_W   (DATA_W),
    .SP_RESET (SP_RESET)
  ) u_stack_ptr (
    .clk        (clk),
    .rst        (rst),
    .upd        (sp_upd),
    .upd_op     (sp_op_q),
    .cur_op     (sp_select),
    .sp         (sp),
    .stack_addr (stack_addr)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // The TIMEOUT-th consecutive BUSY cycle without ack ends the access.
  assign tmo_hit = (state == BUSY) && !mem_ack &&
                   (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Count ack-less BUSY cycles from BUSY entry; latch the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      if ((state == IDLE) && access) begin
        tmo_cnt <= '0;
      end else if ((state == BUSY) && !mem_ack) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if (tmo_hit) begin
        mem_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Access FSM: latch the request in IDLE, hold it through BUSY, release in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sp_op_q   <= SP_NONE;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            mem_addr  <= acc_addr;
            mem_wdata <= wr_data;
            mem_we    <= mem_wr;
            sp_op_q   <= sp_select;
            mem_req   <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            // A read-modify issues the write; its read data is discarded.
            rdata_q <= mem_we ? '0 : mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB register: advance when the pipeline moves, insert a bubble on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data <= '0;
      wb_dst  <= '0;
      wb_wr   <= 1'b0;
    end else if (stall) begin
      wb_wr <= 1'b0;
    end else begin
      wb_data <= wb_sel ? rdata_q : alu_out;
      wb_dst  <= reg_dst;
      wb_wr   <= reg_wr;
    end
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller that consumes the outputs of the EX/MEM pipeline register and performs the data-memory access they describe. It owns the stack pointer, drives a request/acknowledge data-memory port, and produces the MEM/WB writeback bundle. It also generates the `stall` that holds the upstream pipeline registers while a memory access is outstanding.

## Interface
Parameters:
- `DATA_W`, 32: datapath and address width.
- `SP_RESET`, 32'h0000_FFFC: stack pointer value after reset.
- `TIMEOUT`, 15: maximum cycles spent waiting for `mem_ack`. Used only with `MEM_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `alu_out` in DATA_W: EX/MEM ALU result; the memory address when `mem_addr_sel`=0.
- `wr_data` in DATA_W: store data.
- `reg_dst` in 4: destination register.
- `reg_wr` in 1: register write enable.
- `wb_sel` in 1: 1 selects load data for writeback and requests a memory read.
- `mem_addr_sel` in 1: 0 selects `alu_out` as the address, 1 selects the stack pointer.
- `mem_wr` in 1: memory write request.
- `sp_select` in 2: stack operation; 00 none, 01 push, 10 pop, 11 treated as none.
- `mem_req` out 1: memory request; held high until acknowledged.
- `mem_we` out 1: write qualifier for `mem_req`.
- `mem_addr` out DATA_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_ack` in 1: one-cycle acknowledge from memory.
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`.
- `stall` out 1: holds the upstream pipeline registers.
- `wb_data` out DATA_W: registered writeback data.
- `wb_dst` out 4: registered writeback destination.
- `wb_wr` out 1: registered writeback enable.
- `sp` out DATA_W: current stack pointer.
- `mem_err` out 1: sticky timeout flag.

## Operation
- An access occurs when `access = wb_sel | mem_wr`. When `wb_sel` and `mem_wr` are both set, the operation is a read-modify: the write is issued and the read data is ignored.
- Address selection:
  - `mem_addr_sel`=0: `alu_out`.
  - `mem_addr_sel`=1 with push: `sp-4`.
  - `mem_addr_sel`=1 otherwise: `sp`.
- Stack pointer updates happen only on access completion with an ack. Push: `sp <= sp-4`. Pop: `sp <= sp+4`. Arithmetic is modulo 2^DATA_W, so wrap-around is silent.
- `sp_select` without an access is ignored.
- State machine:
  - IDLE: if `access`, latch address, data and `mem_we`, then go to BUSY.
  - BUSY: `mem_req`=1. On `mem_ack`, capture `mem_rdata`, apply the SP update, go to DONE.
  - DONE: go to IDLE unconditionally; `access` is not re-evaluated in this state.
- `stall = (IDLE & access) | BUSY`. It is combinational from state and inputs.
- Writeback register:
  - When `stall`=0: `wb_data <= wb_sel ? captured rdata : alu_out`; `wb_dst <= reg_dst`; `wb_wr <= reg_wr`.
  - When `stall`=1: `wb_wr <= 0` (bubble); `wb_data` and `wb_dst` hold.
- `mem_ack` outside BUSY is ignored.
- `mem_addr`, `mem_wdata` and `mem_we` are stable throughout BUSY.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `wb_data`=0, `wb_dst`=0, `wb_wr`=0, `sp`=SP_RESET, `mem_err`=0, state IDLE.
- `stall` under reset is 0, since the state is IDLE and the inputs are cleared.
- Non-memory instruction: zero added latency; writeback is registered one cycle after presentation.
- Memory access with ack in the first BUSY cycle:
  - Stall is high for 2 cycles (IDLE detect, BUSY).
  - The DONE cycle releases the pipeline.
  - The writeback register updates on the DONE edge.
- Each extra wait cycle before `mem_ack` adds one stall cycle.
- Back-to-back accesses: DONE→IDLE adds one cycle, so the next access is detected in the following IDLE cycle.
- Reset asserted mid-BUSY drops `mem_req` immediately (asynchronous); there is no SP update and no writeback.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on BUSY entry and increments each BUSY cycle without ack.
  - On reaching `TIMEOUT`, the block drops `mem_req`, sets sticky `mem_err`, and goes to DONE.
  - Captured rdata is forced to 0 and SP is not updated.
  - Only `rst` clears `mem_err`.
- `MEM_TIMEOUT_EN` undefined: BUSY waits indefinitely, `mem_err` is tied to 0, and there is no counter logic.

## Structure
- Shared package `cpu_pkg`:
  - Constants `SP_NONE`=2'b00, `SP_PUSH`=2'b01, `SP_POP`=2'b10.
  - State enum `mem_state_t` {IDLE, BUSY, DONE}.
  - Default `SP_RESET`.
- Sub-module `stack_ptr`: the SP register with push/pop update, plus the push/pop address-offset mux.

## Test plan
- ALU instruction, `alu_out`=32'h1234, `reg_dst`=5, `reg_wr`=1 → `stall` stays 0; next cycle `wb_data`=32'h1234, `wb_dst`=5, `wb_wr`=1.
- Load from `alu_out`=32'h100, ack on the first BUSY cycle with rdata 32'hCAFE → stall high for 2 cycles, `mem_req` high for 1 cycle, `mem_addr`=32'h100, `mem_we`=0, then `wb_data`=32'hCAFE.
- Push from reset, `wr_data`=32'hAA, ack after 3 waits → `mem_addr`=32'hFFF8, `mem_we`=1, stall high for 5 cycles, `sp`=32'hFFF8 after ack.
- Pop following the push → `mem_addr`=32'hFFF8, `sp` returns to 32'hFFFC, `wb_data`=rdata.
- `rst` pulsed during BUSY → `mem_req` drops in the same cycle, `sp`=32'hFFFC, `wb_wr`=0; a late `mem_ack` is ignored.
- With `MEM_TIMEOUT_EN`, ack never arrives → `mem_req` drops after 15 BUSY cycles, `mem_err`=1 sticky, `wb_data`=0, `sp` unchanged.
